eth_tx_pad_gap: RTL and testbench



---
 rtl/eth_tx_pad_gap.sv | 194 +++++++++++++++++++
 tb/tb_eth_tx_pad_gap.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_pad_gap.sv
// Egress stage toward the 10G MAC: zero-pads runt frames to MIN_BYTES, carries the
// frame error flag and inserts GAP_CYCLES idle cycles. Define ETH_TX_PAD_STATS_EN for counters.
module eth_tx_pad_gap #(
  parameter int MIN_BYTES  = 60,
  parameter int GAP_CYCLES = 2,
  parameter int CNT_W      = 32
) (
  input  logic             eth_clk,
  input  logic             sys_rst156,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic [63:0]      s_axis_tdata,
  input  logic [7:0]       s_axis_tkeep,
  input  logic             s_axis_tlast,
  input  logic             s_axis_tuser,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [63:0]      m_axis_tdata,
  output logic [7:0]       m_axis_tkeep,
  output logic             m_axis_tlast,
  output logic             m_axis_tuser,
  output logic [CNT_W-1:0] stat_frames,
  output logic [CNT_W-1:0] stat_padded
);

  typedef enum logic [1:0] {IDLE, PASS, PAD, GAP} state_t;

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [7:0] MIN_B = 8'(MIN_BYTES);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam state_t AFTER_LAST = (GAP_CYCLES > 0) ? GAP : IDLE;

  state_t           state;
  logic [6:0]       byte_cnt;
  logic             err_acc;
  logic [GAP_W-1:0] gap_cnt;

  logic        out_free;
  logic        in_fire;
  logic [3:0]  beat_bytes;
  logic [7:0]  sum_wide;
  logic [6:0]  new_cnt;
  logic        reach_min;
  logic [7:0]  to_min;
  logic        frame_err;
  logic [63:0] masked_data;

  function automatic logic [3:0] popcount8(input logic [7:0] k);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, k[i]};
    return n;
  endfunction

  function automatic logic [7:0] low_mask(input logic [7:0] n);
    logic [7:0] m;
    for (int i = 0; i < 8; i++) m[i] = (8'(i) < n);
    return m;
  endfunction

  assign out_free      = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = !sys_rst156 && ((state == IDLE) || (state == PASS)) && out_free;
  assign in_fire       = s_axis_tvalid && s_axis_tready;

  // byte_cnt holds the bytes placed before the current beat, so to_min is what is still owed
  assign beat_bytes = popcount8(s_axis_tkeep);
  assign sum_wide   = {1'b0, byte_cnt} + {4'b0000, beat_bytes};
  assign new_cnt    = sum_wide[7] ? 7'h7F : sum_wide[6:0];
  assign reach_min  = ({1'b0, new_cnt} >= MIN_B);
  assign to_min     = MIN_B - {1'b0, byte_cnt};
  assign frame_err  = err_acc | s_axis_tuser;

  always_comb begin
    masked_data = '0;
    for (int i = 0; i < 8; i++)
      if (s_axis_tkeep[i]) masked_data[8*i +: 8] = s_axis_tdata[8*i +: 8];
  end

  always_ff @(posedge eth_clk) begin
    if (sys_rst156) begin
      state         <= IDLE;
      byte_cnt      <= '0;
      err_acc       <= 1'b0;
      gap_cnt       <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
    end else begin
      if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;
      case (state)
        IDLE, PASS: begin
          if (in_fire) begin
            m_axis_tvalid <= 1'b1;
            if (!s_axis_tlast) begin
              m_axis_tdata <= s_axis_tdata;
              m_axis_tkeep <= s_axis_tkeep;
              m_axis_tlast <= 1'b0;
              m_axis_tuser <= 1'b0;
              byte_cnt     <= new_cnt;
              err_acc      <= frame_err;
              state        <= PASS;
            end else if (reach_min) begin
              m_axis_tdata <= s_axis_tdata;
              m_axis_tkeep <= s_axis_tkeep;
              m_axis_tlast <= 1'b1;
              m_axis_tuser <= frame_err;
              byte_cnt     <= '0;
              err_acc      <= 1'b0;
              state        <= AFTER_LAST;
            end else if (to_min <= 8'd8) begin
              // minimum length ends inside this beat: stretch tkeep and close the frame here
              m_axis_tdata <= masked_data;
              m_axis_tkeep <= low_mask(to_min);
              m_axis_tlast <= 1'b1;
              m_axis_tuser <= frame_err;
              byte_cnt     <= '0;
              err_acc      <= 1'b0;
              state        <= AFTER_LAST;
            end else begin
              m_axis_tdata <= masked_data;
              m_axis_tkeep <= 8'hFF;
              m_axis_tlast <= 1'b0;
              m_axis_tuser <= 1'b0;
              byte_cnt     <= byte_cnt + 7'd8;
              err_acc      <= frame_err;
              state        <= PAD;
            end
          end
        end
        PAD: begin
          if (out_free) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= '0;
            if (to_min <= 8'd8) begin
              m_axis_tkeep <= low_mask(to_min);
              m_axis_tlast <= 1'b1;
              m_axis_tuser <= err_acc;
              byte_cnt     <= '0;
              err_acc      <= 1'b0;
              state        <= AFTER_LAST;
            end else begin
              m_axis_tkeep <= 8'hFF;
              m_axis_tlast <= 1'b0;
              m_axis_tuser <= 1'b0;
              byte_cnt     <= byte_cnt + 7'd8;
            end
          end
        end
        GAP: begin
          // the idle window only starts once the tlast beat has left the output register
          if (!m_axis_tvalid) begin
            if (gap_cnt == GAP_LAST) begin
              gap_cnt <= '0;
              state   <= IDLE;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ETH_TX_PAD_STATS_EN
  logic out_padded;
  logic any_load;
  logic pad_load;

  assign any_load = in_fire || ((state == PAD) && out_free);
  assign pad_load = (state == PAD) || (s_axis_tlast && !reach_min);

  // out_padded tags whatever beat sits in the output register; only its tlast value matters
  always_ff @(posedge eth_clk) begin
    if (sys_rst156) begin
      out_padded  <= 1'b0;
      stat_frames <= '0;
      stat_padded <= '0;
    end else begin
      if (any_load) out_padded <= pad_load;
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
        stat_frames <= stat_frames + 1'b1;
        if (out_padded) stat_padded <= stat_padded + 1'b1;
      end
    end
  end
`else
  assign stat_frames = '0;
  assign stat_padded = '0;
`endif

endmodule

// File: tb/tb_eth_tx_pad_gap.sv
// Bench for eth_tx_pad_gap: a frame-level model (zero-pad to MIN_BYTES, OR of tuser on
// tlast, idle gap after each frame) feeds an expected-beat queue checked by one monitor.
module tb_eth_tx_pad_gap;

  localparam int MIN_BYTES  = 60;
  localparam int GAP_CYCLES = 2;
  localparam int CNT_W      = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             s_tvalid = 1'b0;
  logic             s_tready;
  logic [63:0]      s_tdata = '0;
  logic [7:0]       s_tkeep = '0;
  logic             s_tlast = 1'b0;
  logic             s_tuser = 1'b0;
  logic             m_tvalid;
  logic             m_tready = 1'b1;
  logic [63:0]      m_tdata;
  logic [7:0]       m_tkeep;
  logic             m_tlast;
  logic             m_tuser;
  logic [CNT_W-1:0] stat_frames;
  logic [CNT_W-1:0] stat_padded;

  eth_tx_pad_gap #(.MIN_BYTES(MIN_BYTES), .GAP_CYCLES(GAP_CYCLES), .CNT_W(CNT_W)) dut (
    .eth_clk(clk), .sys_rst156(rst),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
    .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
    .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .stat_frames(stat_frames), .stat_padded(stat_padded)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [63:0] exp_data[$];
  logic [7:0]  exp_keep[$];
  bit          exp_last[$];
  bit          exp_user[$];

  bit          bp_en = 1'b0;
  int          acc_cyc, out_cyc;
  int          out_idx = 0, last_beats = 0, gap_left = 0;
  bit          held = 1'b0, post_gap = 1'b0;
  logic [7:0]  user_mask = '0, last_user_mask = '0, last_keep = '0;
  logic [63:0] h_data;
  logic [10:0] h_ctrl;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] keep_of(input int n);
    logic [7:0] k;
    for (int i = 0; i < 8; i++) k[i] = (i < n);
    return k;
  endfunction

  function automatic int model_nbeats(input int len);
    int out_len;
    out_len = (len >= MIN_BYTES) ? len : MIN_BYTES;
    return (out_len + 7) / 8;
  endfunction

  function automatic logic [7:0] model_last_keep(input int len);
    int out_len;
    out_len = (len >= MIN_BYTES) ? len : MIN_BYTES;
    return keep_of(out_len - 8 * (model_nbeats(len) - 1));
  endfunction

  // Builds a frame, queues the beats the model predicts, then drives it beat by beat
  task automatic applyStimulus(input int len, input int user_beat, input bit rand_user);
    byte unsigned fb[];
    bit ub[];
    int nb_in, nb_out, out_len, tmo;
    bit err;
    logic [63:0] d;
    nb_in = (len + 7) / 8;
    fb = new[nb_in * 8];
    ub = new[nb_in];
    err = 1'b0;
    for (int p = 0; p < nb_in * 8; p++) fb[p] = (p < len) ? 8'($urandom) : 8'hA5;
    for (int b = 0; b < nb_in; b++) begin
      ub[b] = (b == user_beat) || (rand_user && ($urandom_range(0, 15) == 0));
      err |= ub[b];
    end
    out_len = (len >= MIN_BYTES) ? len : MIN_BYTES;
    nb_out = model_nbeats(len);
    for (int b = 0; b < nb_out; b++) begin
      for (int j = 0; j < 8; j++) begin
        int p;
        p = 8 * b + j;
        d[8*j +: 8] = (p < len || (len >= MIN_BYTES && p < nb_in * 8)) ? fb[p] : 8'h00;
      end
      exp_data.push_back(d);
      exp_keep.push_back(keep_of(out_len - 8 * b));
      exp_last.push_back(b == nb_out - 1);
      exp_user.push_back((b == nb_out - 1) && err);
    end
    for (int b = 0; b < nb_in; b++) begin
      for (int j = 0; j < 8; j++) d[8*j +: 8] = fb[8 * b + j];
      s_tdata  = d;
      s_tkeep  = (b == nb_in - 1) ? keep_of(len - 8 * b) : 8'hFF;
      s_tlast  = (b == nb_in - 1);
      s_tuser  = ub[b];
      s_tvalid = 1'b1;
      tmo = 0;
      do begin
        @(negedge clk);
        tmo++;
      end while (!s_tready && tmo < 5000);
      if (!s_tready) begin
        checks++;
        errors++;
        $display("[TB] FAIL accept_timeout: s_axis_tready=%0b, required 1", s_tready);
        s_tvalid = 1'b0;
        return;
      end
      if (b == 0) acc_cyc = cyc;
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((exp_data.size() != 0 || gap_left != 0 || post_gap) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: %0d beats still owed, required 0", exp_data.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Random output backpressure, active only while bp_en is set
  initial forever begin
    @(posedge clk);
    #1;
    if (bp_en) m_tready = 1'($urandom_range(0, 1));
  end

  // Single compare process: beat contents, stall stability and the post-frame idle gap
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0; gap_left = 0; post_gap = 1'b0; out_idx = 0; user_mask = '0;
    end else begin
      if (held) begin
        checkOutput("stall_data", m_tdata, h_data);
        checkOutput("stall_ctrl", 64'({m_tvalid, m_tkeep, m_tlast, m_tuser}), 64'(h_ctrl));
        held = 1'b0;
      end
      if (gap_left > 0) begin
        checkOutput("gap_idle", 64'({m_tvalid, s_tready}), 64'(0));
        gap_left--;
        if (gap_left == 0) post_gap = 1'b1;
      end else if (post_gap) begin
        checkOutput("gap_release", 64'(s_tready), 64'(1));
        post_gap = 1'b0;
      end
      if (m_tvalid && m_tready) begin
        if (exp_data.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_beat: got data %h, required no beat", m_tdata);
        end else begin
          bit e_last, e_user;
          checkOutput("beat_data", m_tdata, exp_data.pop_front());
          checkOutput("beat_keep", 64'(m_tkeep), 64'(exp_keep.pop_front()));
          e_last = exp_last.pop_front();
          e_user = exp_user.pop_front();
          checkOutput("beat_last_user", 64'({m_tlast, m_tuser}), 64'({e_last, e_user}));
        end
        if (out_idx == 0) out_cyc = cyc;
        if (out_idx < 8) user_mask[out_idx] = m_tuser;
        out_idx++;
        if (m_tlast) begin
          last_beats = out_idx;
          last_keep = m_tkeep;
          last_user_mask = user_mask;
          out_idx = 0;
          user_mask = '0;
          gap_left = GAP_CYCLES;
        end
      end else if (m_tvalid) begin
        held = 1'b1;
        h_data = m_tdata;
        h_ctrl = {m_tvalid, m_tkeep, m_tlast, m_tuser};
      end
    end
  end

  initial begin
    // Pin the model on hand-computed shapes
    checkOutput("pin_nbeats_14", 64'(model_nbeats(14)), 64'(8));
    checkOutput("pin_keep_14", 64'(model_last_keep(14)), 64'(8'h0F));
    checkOutput("pin_keep_57", 64'(model_last_keep(57)), 64'(8'h0F));
    checkOutput("pin_keep_64", 64'(model_last_keep(64)), 64'(8'hFF));
    checkOutput("pin_nbeats_100", 64'(model_nbeats(100)), 64'(13));
    checkOutput("pin_keep_100", 64'(model_last_keep(100)), 64'(8'h0F));

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_tready", 64'(s_tready), 64'(0));
    checkOutput("rst_tvalid", 64'(m_tvalid), 64'(0));
    checkOutput("rst_tdata", m_tdata, 64'(0));
    checkOutput("rst_ctrl", 64'({m_tkeep, m_tlast, m_tuser}), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("tready_after_rst", 64'(s_tready), 64'(1));
    @(posedge clk);
    #1;

    applyStimulus(64, -1, 1'b0);
    waitDrain();
    checkOutput("latency_64", 64'(out_cyc - acc_cyc), 64'(1));
    checkOutput("beats_64", 64'(last_beats), 64'(8));
    checkOutput("lastkeep_64", 64'(last_keep), 64'(8'hFF));

    applyStimulus(14, -1, 1'b0);
    waitDrain();
    checkOutput("beats_14", 64'(last_beats), 64'(8));
    checkOutput("lastkeep_14", 64'(last_keep), 64'(8'h0F));

    applyStimulus(57, -1, 1'b0);
    waitDrain();
    checkOutput("beats_57", 64'(last_beats), 64'(8));
    checkOutput("lastkeep_57", 64'(last_keep), 64'(8'h0F));

    applyStimulus(20, 0, 1'b0);
    waitDrain();
    checkOutput("tuser_mask_20", 64'(last_user_mask), 64'(8'h80));

    applyStimulus(5, -1, 1'b0);
    waitDrain();
    checkOutput("beats_5", 64'(last_beats), 64'(8));

    for (int len = 59; len <= 61; len++) begin
      applyStimulus(len, -1, 1'b0);
      waitDrain();
      checkOutput("beats_59_61", 64'(last_beats), 64'(8));
    end

`ifdef ETH_TX_PAD_STATS_EN
    checkOutput("stat_frames_8", 64'(stat_frames), 64'(8));
    checkOutput("stat_padded_5", 64'(stat_padded), 64'(5));
`else
    checkOutput("stats_tied", 64'({stat_frames, stat_padded}), 64'(0));
`endif

    bp_en = 1'b1;
    for (int f = 0; f < 100; f++) begin
      int len;
      len = ($urandom_range(0, 1) == 0) ? $urandom_range(14, 70) : $urandom_range(14, 1500);
      applyStimulus(len, -1, 1'b1);
    end
    waitDrain();
    bp_en = 1'b0;
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    @(posedge clk);
    #1;

    // Reset while the 14-byte frame is being padded
    applyStimulus(14, -1, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_data.delete();
    exp_keep.delete();
    exp_last.delete();
    exp_user.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("tvalid_after_mid_rst", 64'(m_tvalid), 64'(0));
    checkOutput("tready_after_mid_rst", 64'(s_tready), 64'(1));
`ifdef ETH_TX_PAD_STATS_EN
    checkOutput("stat_frames_rst", 64'(stat_frames), 64'(0));
`endif
    @(posedge clk);
    #1;

    applyStimulus(64, -1, 1'b0);
    waitDrain();
    checkOutput("beats_64_after_rst", 64'(last_beats), 64'(8));
    checkOutput("lastkeep_64_after_rst", 64'(last_keep), 64'(8'hFF));
    applyStimulus(14, -1, 1'b0);
    waitDrain();
    applyStimulus(100, -1, 1'b0);
    waitDrain();
    checkOutput("beats_100", 64'(last_beats), 64'(13));

`ifdef ETH_TX_PAD_STATS_EN
    checkOutput("stat_frames_3", 64'(stat_frames), 64'(3));
    checkOutput("stat_padded_1", 64'(stat_padded), 64'(1));
`else
    checkOutput("stats_tied_end", 64'({stat_frames, stat_padded}), 64'(0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
